result_stream_packer: RTL and testbench

RESULT_STREAM_PACKER -- requirements
Module: result_stream_packer

---
 rtl/result_stream_packer_pkg.sv | 36 +++
 rtl/result_stream_packer_sync_fifo_fwft.sv | 62 ++++++
 rtl/result_stream_packer.sv | 123 ++++++++++++
 tb/tb_result_stream_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/result_stream_packer_pkg.sv
// rtl/result_stream_packer_pkg.sv - shared dimensions, FSM encoding and helpers for the result stream packer
//
// Holds the default feature-map geometry, the packer FSM state type and
// small elaboration-time helpers used to size counters from parameters.
package result_stream_packer_pkg;

  // Input image geometry; the block output is downsampled by 4 in each axis.
  localparam int IMG_WIDTH  = 224;
  localparam int IMG_HEIGHT = 224;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WIDTH      = IMG_WIDTH >> 2;
  localparam int DEF_HEIGHT     = IMG_HEIGHT >> 2;
  localparam int DEF_NUM_IMG    = 1;
  localparam int DEF_FIFO_DEPTH = 16;

  // Words per frame at the default geometry.
  localparam int FRAME_WORDS = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } pack_state_e;

  // Words per frame for an arbitrary parameterisation.
  function automatic int frame_words(input int w, input int h);
    return w * h;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_stream_packer_sync_fifo_fwft.sv
// rtl/result_stream_packer_sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset (clears pointers/count)
//   push         write request; honoured when not full, or when full and popping
//   wr_data      entry written on an accepted push
//   pop          read request; honoured when not empty
//   rd_data      head entry, combinational from storage
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/result_stream_packer.sv
// rtl/result_stream_packer.sv - buffers block results into a framed, class-tagged output stream
//
// Ports:
//   clk, resetn     clock and synchronous active-low reset
//   valid_in        data_in/image_class_in valid; no backpressure upstream
//   data_in         result word
//   image_class_in  class bit travelling with the word
//   m_ready         downstream accepts the head word
//   m_valid         m_data/m_last/m_class valid
//   m_data          head word (0 when empty)
//   m_last          head word is the final word of a frame
//   m_class         class bit of the head word
//   overflow        sticky: a word arrived while full and was dropped
//   frame_cnt       frames whose last word has been popped
//   done            sticky: all NUM_IMG frames drained
module result_stream_packer
  import result_stream_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int NUM_IMG    = DEF_NUM_IMG,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  image_class_in,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_class,
  output logic                  overflow,
  output logic [15:0]           frame_cnt,
  output logic                  done
);

  localparam int FW = frame_words(WIDTH, HEIGHT);
  localparam int WW = cnt_width(FW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_WIDTH + 2;

  pack_state_e     state;
  pack_state_e     state_next;
  logic [WW-1:0]   wr_word;
  logic [15:0]     wr_frame;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   head;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            last_tag;
  logic            frame_end;

  // Input is only considered while frames are still being collected.
  assign push_req  = valid_in && (state == ST_RUN);
  assign pop       = m_ready && !fifo_empty;
  assign push      = push_req && (!fifo_full || pop);
  assign last_tag  = (wr_word == WW'(FW - 1));
  assign frame_end = push && last_tag;

  // Gate the head fields so stale storage never shows while empty.
  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? head[EW-1:2] : '0;
  assign m_class = m_valid && head[1];
  assign m_last  = m_valid && head[0];
  assign done    = (state == ST_DONE);

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .wr_data ({data_in, image_class_in, last_tag}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        // Leave on the push that completes the final frame, so no stray
        // word can slip in behind it.
        if (frame_end && (wr_frame == 16'(NUM_IMG - 1))) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && m_last && (frame_cnt == 16'(NUM_IMG - 1))) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_word   <= '0;
      wr_frame  <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_word <= last_tag ? '0 : wr_word + WW'(1);
      if (frame_end) wr_frame <= wr_frame + 16'd1;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      if (pop && m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_result_stream_packer.sv
// tb/tb_result_stream_packer.sv - directed self-checking bench for result_stream_packer
module tb_result_stream_packer;

  logic        clk;
  logic        resetn;
  logic        valid_in;
  logic [31:0] data_in;
  logic        image_class_in;
  logic        m_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_class;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic        done;

  int errors = 0;
  int checks = 0;

  result_stream_packer #(
    .DATA_WIDTH (32),
    .WIDTH      (2),
    .HEIGHT     (2),
    .NUM_IMG    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .image_class_in (image_class_in),
    .m_ready        (m_ready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_class        (m_class),
    .overflow       (overflow),
    .frame_cnt      (frame_cnt),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; valid_in = 1'b0; m_ready = 1'b0; data_in = '0; image_class_in = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid_in = 1'b0; m_ready = 1'b0; data_in = 32'hdead_beef; image_class_in = 1'b1;
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %0b want 0", m_last); end
    checks++; if (m_class !== 1'b0) begin errors++; $display("FAIL reset_m_class: got %0b want 0", m_class); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    resetn = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    m_ready = 1'b1;
    image_class_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      valid_in = 1'b1;
      data_in = 32'(k);
      tick();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", k, m_valid); end
      checks++; if (m_data !== 32'(k)) begin errors++; $display("FAIL stream_data[%0d]: got %0h want %0h", k, m_data, k); end
      checks++; if (m_last !== ((k % 4) == 0)) begin errors++; $display("FAIL stream_last[%0d]: got %0b want %0b", k, m_last, ((k % 4) == 0)); end
      checks++; if (m_class !== 1'b1) begin errors++; $display("FAIL stream_class[%0d]: got %0b want 1", k, m_class); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_early_done[%0d]: got %0b want 0", k, done); end
    end
    valid_in = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done: got %0b want 1", done); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stream_frame_cnt: got %0d want 2", frame_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      data_in = 32'h11 + 32'(k);
      image_class_in = k[0];
      tick();
    end
    valid_in = 1'b0;
    tick();
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d want 4", dut.u_fifo.count); end
    checks++; if (m_data !== 32'h11) begin errors++; $display("FAIL bp_hold_data: got %0h want 11", m_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_no_overflow: got %0b want 0", overflow); end
    valid_in = 1'b1;
    data_in = 32'h15;
    tick();
    valid_in = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %0b want 1", overflow); end
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL bp_count_after_drop: got %0d want 4", dut.u_fifo.count); end
    checks++; if (m_data !== 32'h11) begin errors++; $display("FAIL bp_hold_after_drop: got %0h want 11", m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %0b want 1", i, m_valid); end
      checks++; if (m_data !== 32'h11 + 32'(i)) begin errors++; $display("FAIL bp_drain_data[%0d]: got %0h want %0h", i, m_data, 32'h11 + 32'(i)); end
      checks++; if (m_class !== i[0]) begin errors++; $display("FAIL bp_drain_class[%0d]: got %0b want %0b", i, m_class, i[0]); end
      checks++; if (m_last !== (i == 3)) begin errors++; $display("FAIL bp_drain_last[%0d]: got %0b want %0b", i, m_last, (i == 3)); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b want 0", m_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    m_ready = 1'b0;
    image_class_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      data_in = 32'h21 + 32'(k);
      tick();
    end
    data_in = 32'h25;
    m_ready = 1'b1;
    tick();
    valid_in = 1'b0;
    m_ready = 1'b0;
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", dut.u_fifo.count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b want 0", overflow); end
    checks++; if (m_data !== 32'h22) begin errors++; $display("FAIL fpp_head: got %0h want 22", m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_data !== 32'h22 + 32'(i)) begin errors++; $display("FAIL fpp_drain_data[%0d]: got %0h want %0h", i, m_data, 32'h22 + 32'(i)); end
      checks++; if (m_last !== (i == 2)) begin errors++; $display("FAIL fpp_drain_last[%0d]: got %0b want %0b", i, m_last, (i == 2)); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %0b want 0", m_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL fpp_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    m_ready = 1'b0;
    image_class_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      data_in = 32'h31 + 32'(k);
      tick();
    end
    valid_in = 1'b0;
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL mr_count_before: got %0d want 3", dut.u_fifo.count); end
    resetn = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_after_reset: got %0b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL mr_data_after_reset: got %0h want 0", m_data); end
    resetn = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      data_in = 32'h41 + 32'(k);
      tick();
      checks++; if (m_data !== 32'h41 + 32'(k)) begin errors++; $display("FAIL mr_data[%0d]: got %0h want %0h", k, m_data, 32'h41 + 32'(k)); end
      checks++; if (m_last !== (k == 3)) begin errors++; $display("FAIL mr_last[%0d]: got %0b want %0b", k, m_last, (k == 3)); end
    end
    valid_in = 1'b0;
    tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mr_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_done: got %0b want 0", done); end
  endtask

  task automatic test_post_done();
    do_reset();
    m_ready = 1'b1;
    image_class_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid_in = 1'b1;
      data_in = 32'h51 + 32'(k);
      tick();
    end
    valid_in = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pd_done: got %0b want 1", done); end
    for (int p = 0; p < 5; p++) begin
      valid_in = 1'b1;
      data_in = 32'h99;
      tick();
      valid_in = 1'b0;
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pd_valid[%0d]: got %0b want 0", p, m_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pd_overflow[%0d]: got %0b want 0", p, overflow); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL pd_frame_cnt: got %0d want 2", frame_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pd_done_held: got %0b want 1", done); end
  endtask

  initial begin
    resetn = 1'b0; valid_in = 1'b0; m_ready = 1'b0; data_in = '0; image_class_in = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_mid_reset();
    test_post_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
